// File: rtl/onchip_ram_dp_pkg.sv
// onchip_ram_dp_pkg: clear-engine state and legal read-latency values shared by the RAM slice.
package onchip_ram_dp_pkg;
  typedef enum logic {IDLE, CLEAR} clr_state_e;
  localparam int RL_SHORT = 1;
  localparam int RL_LONG = 2;
endpackage

// File: rtl/onchip_ram_dp_if.sv
// onchip_ram_dp_if: one Avalon-style slave port of the dual-port RAM.
interface onchip_ram_dp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 15
);
  logic [ADDR_W-1:0]   address;
  logic                chipselect;
  logic                read;
  logic                write;
  logic [DATA_W/8-1:0] byteenable;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;
  logic                waitrequest;
  modport master (output address, chipselect, read, write, byteenable, writedata,
                  input readdata, readdatavalid, waitrequest);
  modport slave (input address, chipselect, read, write, byteenable, writedata,
                 output readdata, readdatavalid, waitrequest);
endinterface

// File: rtl/onchip_ram_dp_ram_tdp_be.sv
// ram_tdp_be: true dual-port byte-enable RAM with registered read; port A wins overlapping lanes.
module ram_tdp_be #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en_i,
  input  logic                a_we_i,
  input  logic                a_re_i,
  input  logic [DATA_W/8-1:0] a_be_i,
  input  logic [ADDR_W-1:0]   a_addr_i,
  input  logic [DATA_W-1:0]   a_wdata_i,
  output logic [DATA_W-1:0]   a_rdata_o,
  input  logic                b_we_i,
  input  logic                b_re_i,
  input  logic [DATA_W/8-1:0] b_be_i,
  input  logic [ADDR_W-1:0]   b_addr_i,
  input  logic [DATA_W-1:0]   b_wdata_i,
  output logic [DATA_W-1:0]   b_rdata_o
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  // B is written first so that A's later assignment takes overlapping lanes
  always_ff @(posedge clk)
    if (en_i)
      for (int i = 0; i < DATA_W/8; i++) begin
        if (b_we_i && b_be_i[i]) mem[b_addr_i][8*i +: 8] <= b_wdata_i[8*i +: 8];
        if (a_we_i && a_be_i[i]) mem[a_addr_i][8*i +: 8] <= a_wdata_i[8*i +: 8];
      end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_rdata_o <= '0;
      b_rdata_o <= '0;
    end else if (en_i) begin
      if (a_re_i) a_rdata_o <= mem[a_addr_i];
      if (b_re_i) b_rdata_o <= mem[b_addr_i];
    end
endmodule

// File: rtl/onchip_ram_dp.sv
// onchip_ram_dp: dual-port on-chip RAM with post-reset zero-fill and 1- or 2-cycle read latency.
module onchip_ram_dp
  import onchip_ram_dp_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 15,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clken,
  output logic busy,
  onchip_ram_dp_if.slave s1,
  onchip_ram_dp_if.slave s2
);
  localparam int DEPTH = 2**ADDR_W;
  clr_state_e state_q, state_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic clearing, s1_acc, s2_acc, s1_re, s2_re;
  logic [1:0] v1_q, v2_q;
  logic [DATA_W-1:0] ra, rb, s1_out_q, s2_out_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      cnt_q   <= '0;
    end else if (clken) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  // counter is one bit wider than the address so reaching DEPTH never aliases to 0
  always_comb begin
    cnt_d   = (state_q == CLEAR) ? cnt_q + 1'b1 : cnt_q;
    state_d = (state_q == CLEAR && cnt_d == DEPTH[ADDR_W:0]) ? IDLE : state_q;
  end
  always_comb begin
    clearing = state_q == CLEAR;
    busy     = clearing;
  end
  assign s1.waitrequest = clearing || !clken;
  assign s2.waitrequest = clearing || !clken;
  assign s1_acc = clken && !clearing && s1.chipselect && (s1.read || s1.write);
  assign s2_acc = clken && !clearing && s2.chipselect && (s2.read || s2.write);
  assign s1_re  = s1_acc && !s1.write;
  assign s2_re  = s2_acc && !s2.write;
  ram_tdp_be #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk       (clk),
    .rst       (reset),
    .en_i      (clken),
    .a_we_i    (clearing || (s1_acc && s1.write)),
    .a_re_i    (s1_re),
    .a_be_i    (clearing ? '1 : s1.byteenable),
    .a_addr_i  (clearing ? cnt_q[ADDR_W-1:0] : s1.address),
    .a_wdata_i (clearing ? '0 : s1.writedata),
    .a_rdata_o (ra),
    .b_we_i    (s2_acc && s2.write),
    .b_re_i    (s2_re),
    .b_be_i    (s2.byteenable),
    .b_addr_i  (s2.address),
    .b_wdata_i (s2.writedata),
    .b_rdata_o (rb)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      v1_q     <= '0;
      v2_q     <= '0;
      s1_out_q <= '0;
      s2_out_q <= '0;
    end else if (clken) begin
      v1_q <= {s2_re, s1_re};
      v2_q <= v1_q;
      if (v1_q[0]) s1_out_q <= ra;
      if (v1_q[1]) s2_out_q <= rb;
    end
  assign s1.readdata      = (READ_LATENCY == RL_SHORT) ? ra : s1_out_q;
  assign s2.readdata      = (READ_LATENCY == RL_SHORT) ? rb : s2_out_q;
  assign s1.readdatavalid = (READ_LATENCY == RL_SHORT) ? v1_q[0] : v2_q[0];
  assign s2.readdatavalid = (READ_LATENCY == RL_SHORT) ? v1_q[1] : v2_q[1];
endmodule

// File: tb/tb_onchip_ram_dp.sv
// tb_onchip_ram_dp: scoreboard bench for onchip_ram_dp with a 16-word array.
module tb_onchip_ram_dp;
  localparam int DW = 32, AW = 4, RL = 2, DEPTH = 16;
  logic clk = 1'b0, reset = 1'b1, clken = 1'b1, busy;
  int n_chk = 0, n_fail = 0;
  logic [31:0] model [DEPTH];
  logic [31:0] q1 [$], q2 [$];
  onchip_ram_dp_if #(.DATA_W(DW), .ADDR_W(AW)) s1_if ();
  onchip_ram_dp_if #(.DATA_W(DW), .ADDR_W(AW)) s2_if ();
  onchip_ram_dp #(.DATA_W(DW), .ADDR_W(AW), .READ_LATENCY(RL), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .reset(reset), .clken(clken), .busy(busy), .s1(s1_if.slave), .s2(s2_if.slave)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // a word is delivered when valid is seen on a cycle whose edge is enabled
  always @(negedge clk)
    if (!reset && clken) begin
      if (s1_if.readdatavalid) begin
        if (q1.size() == 0) check("s1_spurious_valid", 32'd1, 32'd0);
        else check("s1_rdata", s1_if.readdata, q1.pop_front());
      end
      if (s2_if.readdatavalid) begin
        if (q2.size() == 0) check("s2_spurious_valid", 32'd1, 32'd0);
        else check("s2_rdata", s2_if.readdata, q2.pop_front());
      end
    end
  task automatic drive(input logic r1, input logic w1, input logic [3:0] a1, input logic [3:0] be1,
                       input logic [31:0] d1, input logic r2, input logic w2, input logic [3:0] a2,
                       input logic [3:0] be2, input logic [31:0] d2);
    s1_if.chipselect = r1 || w1; s1_if.read = r1; s1_if.write = w1;
    s1_if.address = a1; s1_if.byteenable = be1; s1_if.writedata = d1;
    s2_if.chipselect = r2 || w2; s2_if.read = r2; s2_if.write = w2;
    s2_if.address = a2; s2_if.byteenable = be2; s2_if.writedata = d2;
    #1;
    check("s1_wait", 32'(s1_if.waitrequest), 32'(!clken));
    check("s2_wait", 32'(s2_if.waitrequest), 32'(!clken));
    if (clken) begin
      if (r1 && !w1) q1.push_back(model[a1]);
      if (r2 && !w2) q2.push_back(model[a2]);
      for (int b = 0; b < 4; b++) begin
        if (w2 && be2[b]) model[a2][8*b +: 8] = d2[8*b +: 8];
        if (w1 && be1[b]) model[a1][8*b +: 8] = d1[8*b +: 8];
      end
    end
    @(posedge clk); #1;
  endtask
  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 4'd0, 4'h0, 32'h0, 1'b0, 1'b0, 4'd0, 4'h0, 32'h0);
  endtask
  task automatic clear_len(input string tag);
    int n = 0;
    check({tag, "_wait"}, {30'd0, s1_if.waitrequest, s2_if.waitrequest}, 32'd3);
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, n, DEPTH);
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
  endtask
  initial begin
    s1_if.chipselect = 0; s1_if.read = 0; s1_if.write = 0; s1_if.address = '0;
    s1_if.byteenable = '0; s1_if.writedata = '0;
    s2_if.chipselect = 0; s2_if.read = 0; s2_if.write = 0; s2_if.address = '0;
    s2_if.byteenable = '0; s2_if.writedata = '0;
    repeat (3) @(posedge clk); #1;
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_rdv", {30'd0, s1_if.readdatavalid, s2_if.readdatavalid}, 32'd0);
    check("rst_rdata1", s1_if.readdata, 32'h0);
    check("rst_rdata2", s2_if.readdata, 32'h0);
    reset = 1'b0;
    clear_len("clear_len");
    for (int i = 0; i < DEPTH; i++)
      drive(1'b1, 1'b0, 4'(i), 4'h0, 32'h0, 1'b1, 1'b0, 4'(DEPTH-1-i), 4'h0, 32'h0);
    idle(3);
    drive(1'b0, 1'b1, 4'd3, 4'b0101, 32'hDEADBEEF, 1'b0, 1'b0, 4'd0, 4'h0, 32'h0);
    check("model_be", model[3], 32'h00AD00EF);
    drive(1'b1, 1'b0, 4'd3, 4'h0, 32'h0, 1'b0, 1'b0, 4'd0, 4'h0, 32'h0);
    check("lat_e0", 32'(s1_if.readdatavalid), 32'(RL == 1));
    idle(1);
    check("lat_e1", 32'(s1_if.readdatavalid), 32'(RL == 2));
    idle(1);
    check("lat_e2", 32'(s1_if.readdatavalid), 32'd0);
    idle(1);
    drive(1'b0, 1'b1, 4'd5, 4'b0011, 32'h11111111, 1'b0, 1'b1, 4'd5, 4'b1111, 32'h22222222);
    check("model_lane", model[5], 32'h22221111);
    drive(1'b1, 1'b0, 4'd5, 4'h0, 32'h0, 1'b1, 1'b0, 4'd5, 4'h0, 32'h0);
    drive(1'b0, 1'b1, 4'd7, 4'hF, 32'hA5A5A5A5, 1'b1, 1'b0, 4'd7, 4'h0, 32'h0);
    drive(1'b0, 1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 1'b0, 4'd7, 4'h0, 32'h0);
    drive(1'b1, 1'b1, 4'd9, 4'hF, 32'h12345678, 1'b0, 1'b0, 4'd0, 4'h0, 32'h0);
    drive(1'b1, 1'b0, 4'd9, 4'h0, 32'h0, 1'b0, 1'b0, 4'd0, 4'h0, 32'h0);
    for (int i = 0; i < 3; i++)
      drive(1'b0, 1'b0, 4'd0, 4'h0, 32'h0, 1'b0, 1'b1, 4'(i), 4'hF, 32'hC0DE0000 + 32'(i));
    drive(1'b1, 1'b0, 4'd0, 4'h0, 32'h0, 1'b0, 1'b0, 4'd0, 4'h0, 32'h0);
    drive(1'b1, 1'b0, 4'd1, 4'h0, 32'h0, 1'b0, 1'b0, 4'd0, 4'h0, 32'h0);
    clken = 1'b0;
    drive(1'b1, 1'b0, 4'd2, 4'h0, 32'h0, 1'b0, 1'b0, 4'd0, 4'h0, 32'h0);
    drive(1'b1, 1'b0, 4'd2, 4'h0, 32'h0, 1'b0, 1'b0, 4'd0, 4'h0, 32'h0);
    clken = 1'b1;
    drive(1'b1, 1'b0, 4'd2, 4'h0, 32'h0, 1'b0, 1'b0, 4'd0, 4'h0, 32'h0);
    drive(1'b1, 1'b0, 4'd3, 4'h0, 32'h0, 1'b0, 1'b0, 4'd0, 4'h0, 32'h0);
    idle(4);
    check("s1_drain", q1.size(), 32'd0);
    check("s2_drain", q2.size(), 32'd0);
    s1_if.chipselect = 1'b1; s1_if.read = 1'b1; s1_if.address = 4'd4;
    @(posedge clk); #1;
    reset = 1'b1;
    s1_if.chipselect = 1'b0; s1_if.read = 1'b0;
    @(posedge clk); #1;
    check("rst2_busy", 32'(busy), 32'd1);
    check("rst2_rdv", 32'(s1_if.readdatavalid), 32'd0);
    reset = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    check("mid_clear_busy", 32'(busy), 32'd1);
    reset = 1'b1; #2; reset = 1'b0;
    clear_len("reclear_len");
    drive(1'b1, 1'b0, 4'd3, 4'h0, 32'h0, 1'b1, 1'b0, 4'd5, 4'h0, 32'h0);
    drive(1'b1, 1'b0, 4'd7, 4'h0, 32'h0, 1'b1, 1'b0, 4'd9, 4'h0, 32'h0);
    idle(4);
    check("s1_final_drain", q1.size(), 32'd0);
    check("s2_final_drain", q2.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/onchip_ram_dp.md
ONCHIP_RAM_DP -- requirements
Module: onchip_ram_dp

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning data word width in bits (multiple of 8).
REQ-002 The block SHALL have parameter ADDR_W, default 15, meaning word-address width (DEPTH = 2**ADDR_W).
REQ-003 The block SHALL have parameter READ_LATENCY, default 1, meaning cycles from accepted read to readdatavalid (legal values 1 or 2).
REQ-004 The block SHALL have parameter CLEAR_ON_RESET, default 1, meaning zero-fill the whole array after reset.
REQ-005 The block SHALL have port clk  input  1  the single clock; all logic is rising-edge.
REQ-006 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 The block SHALL have port clken  input  1  global clock enable; low freezes all state.
REQ-008 For each port p in {s1, s2}, the block SHALL have: p_address in ADDR_W; p_chipselect in 1; p_read in 1; p_write in 1; p_byteenable in DATA_W/8; p_writedata in DATA_W; p_readdata out DATA_W; p_readdatavalid out 1; p_waitrequest out 1.
REQ-009 The block SHALL have port busy  output  1  high while the clear engine runs.

Function
REQ-010 A port p SHALL accept a transfer in a cycle where p_chipselect=1, (p_read or p_write)=1, p_waitrequest=0 and clken=1.
REQ-011 An accepted write SHALL update only the bytes whose byteenable bit is 1, visible to reads accepted in the next cycle.
REQ-012 An accepted read SHALL drive p_readdata and pulse p_readdatavalid high for exactly one cycle, READ_LATENCY cycles later.
REQ-013 With READ_LATENCY=2, an output register SHALL follow the array register, and both ports SHALL remain fully pipelined at one read per cycle.
REQ-014 p_read and p_write both high SHALL be treated as a write only.
REQ-015 A read and a write to the same address in the same cycle, on the same port or across ports, SHALL return the old data.
REQ-016 Simultaneous writes from s1 and s2 to the same address SHALL resolve per byte lane, with s1 winning on overlapping enabled lanes and s2 lanes applied elsewhere.
REQ-017 The clear engine SHALL have states IDLE and CLEAR; after reset, it SHALL enter CLEAR if CLEAR_ON_RESET=1, else IDLE.
REQ-018 In CLEAR, a counter starting at 0 SHALL write all-zero to one word per enabled cycle, and SHALL go to IDLE after writing address DEPTH-1 (DEPTH enabled cycles in total).
REQ-019 While in CLEAR, busy and both waitrequests SHALL be 1, and no host transfer SHALL be accepted.
REQ-020 When clken=0, the array, pipeline registers, clear counter and readdatavalid SHALL hold, and both waitrequests SHALL be 1.
REQ-021 Outside CLEAR with clken=1, waitrequest SHALL be 0, with no back-pressure.
REQ-022 The counter SHALL be ADDR_W+1 bits wide so that termination at DEPTH is detected without wrap-around to 0.

Reset
REQ-023 Reset SHALL clear p_readdata to 0, p_readdatavalid to 0, all pipeline valid bits to 0, and the clear counter to 0; busy SHALL be 1 if CLEAR_ON_RESET=1, else 0.
REQ-024 Reset asserted mid-CLEAR or mid-read SHALL discard in-flight reads (no readdatavalid) and restart the clear from address 0.
REQ-025 Array contents SHALL NOT be reset by the reset signal itself; only the clear engine zeroes them.

Structure
REQ-026 A shared package SHALL hold the clear-state enum (IDLE, CLEAR) and the legal READ_LATENCY constants.
REQ-027 The storage SHALL be one sub-module, ram_tdp_be (true dual-port, byte-enable, registered read), inferred to block RAM; the top SHALL hold arbitration, the clear engine and the latency pipeline.

Verification
REQ-028 Scenario: reset release with CLEAR_ON_RESET=1, ADDR_W=4 -> busy and waitrequest high for exactly 16 cycles, then low, and reads of all 16 addresses return 0.
REQ-029 Scenario: s1 writes 0xDEADBEEF to address 3 with byteenable 4'b0101, then reads it -> 0x00AD00EF with readdatavalid 1 cycle later (READ_LATENCY=1) or 2 cycles later (READ_LATENCY=2).
REQ-030 Scenario: same cycle, s1 writes 0x11111111 with byteenable 4'b0011 and s2 writes 0x22222222 with byteenable 4'b1111, both to address 5 -> subsequent read returns 0x22221111.
REQ-031 Scenario: s1 writes 0xA5A5A5A5 to address 7 while s2 reads address 7 (old value 0) -> s2 gets 0; the next s2 read gets 0xA5A5A5A5.
REQ-032 Scenario: back-to-back reads of addresses 0..3 with clken low for 2 cycles mid-stream -> four readdatavalid pulses in order, with no loss or duplication.
REQ-033 Scenario: reset pulsed at clear count 9 with one read in flight -> no readdatavalid, and clear restarts at 0 taking the full DEPTH cycles.
